alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the single-cycle datapath ALU.
- Width is set by WIDTH. The opcode set is widened to 4 bits (XOR, NOR, signed SLT, shifts), and iterative unsigned multiply/divide is added with a start/busy/done handshake.
- Sits in the EX stage; the control unit stalls the pipeline while busy=1.
- Opcode encodings 0000/0001/0010/0110/0111 keep the legacy 3-bit meanings (MSB=0).

Parameters:
- WIDTH, 32: operand/result width; must be >=4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- sel  in  4  opcode
- operand1  in  WIDTH  first operand (A)
- operand2  in  WIDTH  second operand (B)
- busy  out  1  high while a MULU/DIVU iterates
- done  out  1  one-cycle pulse; result valid
- resultado  out  WIDTH  result / product low / quotient
- hi  out  WIDTH  product high / remainder; 0 for other ops
- zf  out  1  resultado == 0
- ovf  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Interface: one clock; reset is synchronous and active-low. On a clk edge with rst_n=0:
  - state=IDLE
  - busy, done, zf, ovf cleared; resultado, hi cleared.
  - This applies mid-operation too: the iteration is aborted and no done is issued.
- Opcodes:
  - 0000 AND; 0001 OR; 0011 XOR; 0100 NOR
  - 0010 ADD; 0110 SUB; 0101 SLT signed; 0111 SLTU unsigned (legacy slt)
  - 1000 SLL; 1001 SRL; 1010 SRA. Shift amount is B[SHW-1:0]; upper bits of B are ignored.
  - 1100 MULU; 1101 DIVU
  - All others: resultado=0, hi=0, completes as a single-cycle op.
- Operand capture: operands and sel are captured at the accepting edge. Later input changes do not affect the operation in flight.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start, single-cycle op: compute and register all outputs at edge N; go to DONE. done=1 during cycle N+1.
  - IDLE/DONE + start, MULU/DIVU: busy=1 after edge N; go to RUN with counter=WIDTH.
  - RUN: one shift-add (MULU) or restoring-subtract (DIVU) step per edge. After WIDTH steps, i.e. at edge N+WIDTH: write outputs, busy=0, done=1, go to DONE. Total latency is WIDTH cycles.
  - DONE without start: go to IDLE, done=0.
  - DONE with start: back-to-back accept, so done can be high on consecutive cycles.
  - start while in RUN: ignored, no queuing.
- Widths and flags:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf = carry into MSB XOR carry out, for ADD/SUB only; 0 otherwise.
  - SLT/SLTU yield 0 or 1, zero-extended.
  - MULU: {hi,resultado} = A*B, full 2*WIDTH-bit product.
  - DIVU: resultado = A/B, hi = A%B.
  - DIVU with B=0: single-cycle completion (done at cycle N+1), resultado = all ones, hi = A, ovf=0.
- zf: registered together with resultado (resultado==0 at completion), independent of hi.
- Hold: all result outputs hold between completions and do not change during RUN.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MULU/DIVU are implemented as above; the RUN state and counter exist.
- Undefined: 1100 and 1101 behave as unsupported opcodes (resultado=0, hi=0, zf=1, done after 1 cycle). busy is tied to 0, and no RUN state or counter logic is synthesised.

Test Plan:
- Reset and legacy ops: hold rst_n=0 for 2 cycles, then AND 0xF0F0F0F0 & 0x0FF00FF0 → resultado=0x00F000F0, done at cycle N+1. SLTU 0x00000001 vs 0xFFFFFFFF → 1. SLT on the same operands → 0.
- Overflow and zero flag:
  - ADD 0x7FFFFFFF+1 → 0x80000000, ovf=1, zf=0.
  - SUB 5-5 → 0, zf=1, ovf=0.
  - ADD 0xFFFFFFFF+1 → 0, zf=1, ovf=0.
- Shifts: SRA 0x80000000 by B=0x24 (uses 4) → 0xF8000000. SLL 1 by 31 → 0x80000000.
- MULU: 0xFFFFFFFF*0xFFFFFFFF.
  - busy for 32 cycles; done at edge N+32.
  - hi=0xFFFFFFFE, resultado=0x00000001.
  - start asserted mid-RUN is ignored.
- DIVU:
  - 100/7 → resultado=14, hi=2 after 32 cycles.
  - 100/0 → resultado=0xFFFFFFFF, hi=100, done at cycle N+1.
- Reset mid-op and back-to-back:
  - rst_n=0 at RUN cycle 10 → busy=0, done never pulses, outputs=0.
  - ADD start held during DONE → second result accepted, done high 2 consecutive cycles.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: clocked EX-stage ALU with a start/busy/done handshake.
// Single-cycle ops: AND, OR, XOR, NOR, ADD, SUB, SLT, SLTU, SLL, SRL, SRA.
// Optional iterative MULU/DIVU, enabled by defining ALU_MULDIV_EN.
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resultado,
   output logic [WIDTH-1:0] hi,
   output logic             zf,
   output logic             ovf
);
   localparam int unsigned SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
`ifdef ALU_MULDIV_EN
   localparam logic [3:0] OP_MULU = 4'b1100;
   localparam logic [3:0] OP_DIVU = 4'b1101;
   localparam int unsigned CW = SHW + 1;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DONE = 2'd1
`ifdef ALU_MULDIV_EN
      , S_RUN = 2'd2
`endif
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_zf, w_zf_nxt;
   logic             r_ovf, w_ovf_nxt;
   logic [WIDTH-1:0] r_res, w_res_nxt;
   logic [WIDTH-1:0] r_hi, w_hi_nxt;

   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_sum, w_diff, w_sc_res, w_sc_hi;
   logic             w_sc_ovf;

`ifdef ALU_MULDIV_EN
   // r_wa: product high / partial remainder; r_wb: multiplier-product low / dividend-quotient
   logic [WIDTH-1:0] r_wa, w_wa_nxt;
   logic [WIDTH-1:0] r_wb, w_wb_nxt;
   logic [WIDTH-1:0] r_d, w_d_nxt;
   logic             r_div, w_div_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [WIDTH:0]   w_madd, w_dshift, w_dsub;
   logic [WIDTH-1:0] w_step_a, w_step_b;
   logic             w_iter_op;
`endif

   // Single-cycle result for the opcode presented with start
   always_comb begin
      w_shamt  = operand2[SHW-1:0];
      w_sum    = operand1 + operand2;
      w_diff   = operand1 - operand2;
      w_sc_res = '0;
      w_sc_hi  = '0;
      w_sc_ovf = 1'b0;
      case (sel)
         OP_AND:  w_sc_res = operand1 & operand2;
         OP_OR:   w_sc_res = operand1 | operand2;
         OP_XOR:  w_sc_res = operand1 ^ operand2;
         OP_NOR:  w_sc_res = ~(operand1 | operand2);
         OP_ADD: begin
            w_sc_res = w_sum;
            w_sc_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != operand1[WIDTH-1]);
         end
         OP_SUB: begin
            w_sc_res = w_diff;
            w_sc_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != operand1[WIDTH-1]);
         end
         OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
         OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
         OP_SLL:  w_sc_res = operand1 << w_shamt;
         OP_SRL:  w_sc_res = operand1 >> w_shamt;
         OP_SRA:  w_sc_res = $signed(operand1) >>> w_shamt;
`ifdef ALU_MULDIV_EN
         OP_DIVU: begin
            // only reached as a single-cycle op when dividing by zero
            w_sc_res = '1;
            w_sc_hi  = operand1;
         end
`endif
         default: w_sc_res = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   // One shift-add multiply or restoring-divide step on the working registers
   always_comb begin
      w_iter_op = (sel == OP_MULU) || ((sel == OP_DIVU) && (operand2 != '0));
      w_madd    = {1'b0, r_wa} + (r_wb[0] ? {1'b0, r_d} : '0);
      w_dshift  = {r_wa, r_wb[WIDTH-1]};
      w_dsub    = w_dshift - {1'b0, r_d};
      if (r_div) begin
         if (!w_dsub[WIDTH]) begin
            w_step_a = w_dsub[WIDTH-1:0];
            w_step_b = {r_wb[WIDTH-2:0], 1'b1};
         end else begin
            w_step_a = w_dshift[WIDTH-1:0];
            w_step_b = {r_wb[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_step_a = w_madd[WIDTH:1];
         w_step_b = {w_madd[0], r_wb[WIDTH-1:1]};
      end
   end
`endif

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_res_nxt   = r_res;
      w_hi_nxt    = r_hi;
      w_zf_nxt    = r_zf;
      w_ovf_nxt   = r_ovf;
`ifdef ALU_MULDIV_EN
      w_wa_nxt    = r_wa;
      w_wb_nxt    = r_wb;
      w_d_nxt     = r_d;
      w_div_nxt   = r_div;
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
`ifdef ALU_MULDIV_EN
               if (w_iter_op) begin
                  w_state_nxt = S_RUN;
                  w_busy_nxt  = 1'b1;
                  w_cnt_nxt   = CW'(WIDTH);
                  w_div_nxt   = (sel == OP_DIVU);
                  w_wa_nxt    = '0;
                  w_wb_nxt    = (sel == OP_DIVU) ? operand1 : operand2;
                  w_d_nxt     = (sel == OP_DIVU) ? operand2 : operand1;
               end else begin
`else
               begin
`endif
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_res_nxt   = w_sc_res;
                  w_hi_nxt    = w_sc_hi;
                  w_zf_nxt    = (w_sc_res == '0);
                  w_ovf_nxt   = w_sc_ovf;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`ifdef ALU_MULDIV_EN
         S_RUN: begin
            w_wa_nxt  = w_step_a;
            w_wb_nxt  = w_step_b;
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
               w_res_nxt   = w_step_b;
               w_hi_nxt    = w_step_a;
               w_zf_nxt    = (w_step_b == '0);
               w_ovf_nxt   = 1'b0;
            end else begin
               w_busy_nxt = 1'b1;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_zf    <= 1'b0;
         r_ovf   <= 1'b0;
         r_res   <= '0;
         r_hi    <= '0;
`ifdef ALU_MULDIV_EN
         r_wa    <= '0;
         r_wb    <= '0;
         r_d     <= '0;
         r_div   <= 1'b0;
         r_cnt   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_zf    <= w_zf_nxt;
         r_ovf   <= w_ovf_nxt;
         r_res   <= w_res_nxt;
         r_hi    <= w_hi_nxt;
`ifdef ALU_MULDIV_EN
         r_wa    <= w_wa_nxt;
         r_wb    <= w_wb_nxt;
         r_d     <= w_d_nxt;
         r_div   <= w_div_nxt;
         r_cnt   <= w_cnt_nxt;
`endif
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign resultado = r_res;
   assign hi        = r_hi;
   assign zf        = r_zf;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32); MULU/DIVU sequences run when ALU_MULDIV_EN is defined.
module tb_alu_seq;
   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [3:0]       sel;
   logic [WIDTH-1:0] operand1, operand2;
   logic             busy, done, zf, ovf;
   logic [WIDTH-1:0] resultado, hi;

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] hi;
      logic        zf;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sel       (sel),
      .operand1  (operand1),
      .operand2  (operand2),
      .busy      (busy),
      .done      (done),
      .resultado (resultado),
      .hi        (hi),
      .zf        (zf),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

`ifdef ALU_MULDIV_EN
   // Waits for done (bounded); reports latency and whether busy/result held during RUN.
   task automatic wait_done(input bit poke, output int lat, output bit hold_ok);
      logic [WIDTH-1:0] prev;
      prev    = resultado;
      lat     = 0;
      hold_ok = 1'b1;
      while (!done && lat < 100) begin
         @(negedge clk);
         if (poke && lat == 5) begin
            start = 1'b1;
            sel   = 4'b0010;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
         if (!done && (busy !== 1'b1 || resultado !== prev)) hold_ok = 1'b0;
      end
   endtask
`endif

   initial begin
      int  lat;
      bit  hold_ok;
      int  pulses;

      rst_n = 1'b0; start = 1'b0; sel = 4'b0; operand1 = '0; operand2 = '0;

      // Reset state after two cycles of rst_n=0
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst res", resultado, 0);
      chk("rst hi", hi, 0);
      chk("rst zf", zf, 0);
      chk("rst ovf", ovf, 0);
      @(negedge clk); rst_n = 1'b1;

      //            sel      a             b             res           hi            zf    ovf
      vecs.push_back('{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0}); // AND
      vecs.push_back('{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0}); // SLTU
      vecs.push_back('{4'b0101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0}); // SLT 1<-1
      vecs.push_back('{4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0}); // SLT -1<1
      vecs.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1}); // ADD ovf
      vecs.push_back('{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0}); // SUB zero
      vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0}); // ADD wrap
      vecs.push_back('{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1}); // SUB ovf
      vecs.push_back('{4'b1010, 32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 1'b0, 1'b0}); // SRA by 4
      vecs.push_back('{4'b1000, 32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 1'b0}); // SLL 31
      vecs.push_back('{4'b1000, 32'h00000001, 32'h00000021, 32'h00000002, 32'h0, 1'b0, 1'b0}); // SLL by 1
      vecs.push_back('{4'b1001, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1'b0}); // SRL
      vecs.push_back('{4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1'b0}); // OR
      vecs.push_back('{4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0, 1'b0, 1'b0}); // XOR
      vecs.push_back('{4'b0100, 32'hF0F0F0F0, 32'h0000FFFF, 32'h0F0F0000, 32'h0, 1'b0, 1'b0}); // NOR
      vecs.push_back('{4'b1111, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0, 1'b1, 1'b0}); // unsupported
`ifdef ALU_MULDIV_EN
      vecs.push_back('{4'b1101, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b0, 1'b0});           // DIVU by 0
`else
      vecs.push_back('{4'b1100, 32'd3, 32'd5, 32'h0, 32'h0, 1'b1, 1'b0});                      // MULU off
      vecs.push_back('{4'b1101, 32'd100, 32'd7, 32'h0, 32'h0, 1'b1, 1'b0});                    // DIVU off
`endif

      // Single-cycle vectors: done during cycle N+1, then drop to idle with outputs held
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         start = 1'b1; sel = vecs[i].sel; operand1 = vecs[i].a; operand2 = vecs[i].b;
         @(posedge clk); #1;
         start = 1'b0; sel = 4'b0010; operand1 = '1; operand2 = '1;
         chk($sformatf("vec%0d done", i), done, 1);
         chk($sformatf("vec%0d busy", i), busy, 0);
         chk($sformatf("vec%0d res", i), resultado, vecs[i].res);
         chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
         chk($sformatf("vec%0d zf", i), zf, vecs[i].zf);
         chk($sformatf("vec%0d ovf", i), ovf, vecs[i].ovf);
         @(posedge clk); #1;
         chk($sformatf("vec%0d done drop", i), done, 0);
         chk($sformatf("vec%0d res hold", i), resultado, vecs[i].res);
      end

`ifdef ALU_MULDIV_EN
      // MULU max*max with a stray start mid-RUN and operands changed after capture
      @(negedge clk);
      start = 1'b1; sel = 4'b1100; operand1 = 32'hFFFFFFFF; operand2 = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0; operand1 = 32'd9; operand2 = 32'd9;
      chk("mulu busy", busy, 1);
      chk("mulu done early", done, 0);
      wait_done(1'b1, lat, hold_ok);
      start = 1'b0;
      chk("mulu latency", lat, 32);
      chk("mulu hold", hold_ok, 1);
      chk("mulu busy end", busy, 0);
      chk("mulu lo", resultado, 32'h00000001);
      chk("mulu hi", hi, 32'hFFFFFFFE);
      chk("mulu zf", zf, 0);
      @(posedge clk); #1;
      chk("mulu done drop", done, 0);

      // DIVU 100/7
      @(negedge clk);
      start = 1'b1; sel = 4'b1101; operand1 = 32'd100; operand2 = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; operand2 = 32'd0;
      wait_done(1'b0, lat, hold_ok);
      chk("divu latency", lat, 32);
      chk("divu hold", hold_ok, 1);
      chk("divu quot", resultado, 32'd14);
      chk("divu rem", hi, 32'd2);
      chk("divu ovf", ovf, 0);

      // Reset during RUN aborts the iteration with no done pulse
      @(negedge clk);
      start = 1'b1; sel = 4'b1100; operand1 = 32'd3; operand2 = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort res", resultado, 0);
      chk("abort hi", hi, 0);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      chk("abort no done", pulses, 0);
`endif

      // Back-to-back ADDs with start held through DONE
      @(negedge clk);
      start = 1'b1; sel = 4'b0010; operand1 = 32'd2; operand2 = 32'd3;
      @(posedge clk); #1;
      chk("b2b done1", done, 1);
      chk("b2b res1", resultado, 32'd5);
      operand1 = 32'd10; operand2 = 32'd20;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b done2", done, 1);
      chk("b2b res2", resultado, 32'd30);
      @(posedge clk); #1;
      chk("b2b done drop", done, 0);

      // Reset clears held nonzero results
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst2 res", resultado, 0);
      chk("rst2 done", done, 0);
      @(negedge clk); rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
